// File: rtl/filter_mac_sequencer_if.sv
// Sample-in / MAC-drive / result-out signal bundle of the FIR sequencer.
// The master side is the sequencer; the slave side is the sample source, MAC and consumer.
interface filter_mac_sequencer_if #(
  parameter int DATA_W = 33,
  parameter int TAP_W  = 4
);
  logic [DATA_W-1:0] inSignal;
  logic              newData;
  logic              macStart;
  logic [DATA_W-1:0] macA;
  logic [TAP_W-1:0]  macTap;
  logic              macFirst;
  logic              macAck;
  logic [DATA_W-1:0] macResult;
  logic [DATA_W-1:0] outSignal;
  logic              dataReady;
  logic              busy;
  logic              overrun;

  modport master (
    input  inSignal, newData, macAck, macResult,
    output macStart, macA, macTap, macFirst, outSignal, dataReady, busy, overrun
  );

  modport slave (
    output inSignal, newData, macAck, macResult,
    input  macStart, macA, macTap, macFirst, outSignal, dataReady, busy, overrun
  );
endinterface

// File: rtl/filter_mac_sequencer.sv
// FIR control path: owns the circular sample delay line and walks an external
// MAC through every tap, one product at a time, for each accepted sample.
module filter_mac_sequencer #(
  parameter int DATA_W = 33,
  parameter int NTAPS  = 11,
  parameter int TAP_W  = 4
) (
  input logic                    clk,
  input logic                    rst,
  filter_mac_sequencer_if.master bus
);
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [TAP_W-1:0] LastTap = TAP_W'(NTAPS - 1);

  state_e            state;
  logic [DATA_W-1:0] delayLine [NTAPS];
  logic [TAP_W-1:0]  wp;
  logic [TAP_W-1:0]  wpNew;
  logic [TAP_W-1:0]  tap;
  logic [TAP_W-1:0]  nextTap;

  // Slot of tap k relative to the newest sample, modulo a non-power-of-2 depth.
  function automatic logic [TAP_W-1:0] tapSlot(input logic [TAP_W-1:0] base,
                                               input logic [TAP_W-1:0] k);
    if (base >= k) return base - k;
    return TAP_W'(int'(base) + NTAPS - int'(k));
  endfunction

  assign nextTap  = tap + TAP_W'(1);
  assign bus.busy = (state != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      wp            <= '0;
      wpNew         <= '0;
      tap           <= '0;
      for (int i = 0; i < NTAPS; i++) delayLine[i] <= '0;
      bus.macStart  <= 1'b0;
      bus.macA      <= '0;
      bus.macTap    <= '0;
      bus.macFirst  <= 1'b0;
      bus.outSignal <= '0;
      bus.dataReady <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.macStart  <= 1'b0;
      bus.dataReady <= 1'b0;
      // Samples arriving mid-sequence are lost; flag it until the next reset.
      if (bus.newData && (state == StIssue || state == StWait)) bus.overrun <= 1'b1;

      case (state)
        StIdle, StDone: begin
          if (bus.newData) begin
            delayLine[wp] <= bus.inSignal;
            wpNew         <= wp;
            wp            <= (wp == LastTap) ? '0 : wp + TAP_W'(1);
            tap           <= '0;
            // Tap 0 is the incoming sample itself, so bypass the delay line.
            bus.macStart  <= 1'b1;
            bus.macTap    <= '0;
            bus.macA      <= bus.inSignal;
            bus.macFirst  <= 1'b1;
            state         <= StIssue;
          end else begin
            state <= StIdle;
          end
        end
        StIssue: state <= StWait;
        StWait: begin
          if (bus.macAck) begin
            if (tap == LastTap) begin
              bus.outSignal <= bus.macResult;
              bus.dataReady <= 1'b1;
              state         <= StDone;
            end else begin
              tap          <= nextTap;
              bus.macStart <= 1'b1;
              bus.macTap   <= nextTap;
              bus.macA     <= delayLine[tapSlot(wpNew, nextTap)];
              bus.macFirst <= 1'b0;
              state        <= StIssue;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_filter_mac_sequencer.sv
// Self-checking bench: cycle-level reference model of the tap walk plus a MAC model
// with configurable ack latency, driven by tables, hand sequences and random samples.
module tb_filter_mac_sequencer;
  localparam int DATA_W = 33;
  localparam int NTAPS  = 11;
  localparam int TAP_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  filter_mac_sequencer_if #(.DATA_W(DATA_W), .TAP_W(TAP_W)) bus ();

  filter_mac_sequencer #(.DATA_W(DATA_W), .NTAPS(NTAPS), .TAP_W(TAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [32:0] sample;
    logic [32:0] expTap1;
    logic [32:0] expTap10;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [32:0] hist[$];          // newest sample at index 0
  logic [32:0] capA[NTAPS];      // macA captured at each tap's start strobe
  logic [32:0] acc, expOut;
  bit          seqActive, startDueNext, doneNext, outstanding, expOv, lastStart, doneSeen;
  int          curTap, countdown, ackDelay;   // ackDelay 0 selects a random 1..7
  int          acceptCyc, readyCyc, accepted, dutReadies;
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [32:0] rnd33();
    logic [32:0] r;
    r[31:0] = $urandom;
    r[32]   = ($urandom_range(0, 1) == 1);
    return r;
  endfunction

  // Stand-in for the float product: any value that depends on sample and tap.
  function automatic logic [32:0] prod(input logic [32:0] s, input int t);
    return s ^ (33'(t) * 33'h0_1357_9BDF) ^ 33'h1_0000_0001;
  endfunction

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < NTAPS; i++) hist.push_back(33'd0);
    seqActive = 0; startDueNext = 0; doneNext = 0; outstanding = 0; expOv = 0;
    lastStart = 0; doneSeen = 0; curTap = -1; countdown = 0; acc = '0; expOut = '0;
    accepted = 0; dutReadies = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then drive the next inputs.
  task automatic step(input bit nd, input logic [32:0] din, input bit atDone);
    bit startNow, doneNow, go;
    @(negedge clk);
    cyc++;
    startNow = startDueNext;
    doneNow  = doneNext;
    startDueNext = 0;
    doneNext     = 0;
    chk("busy", 64'(bus.busy), 64'(seqActive));
    chk("dataReady", 64'(bus.dataReady), 64'(doneNow));
    chk("macStart", 64'(bus.macStart), 64'(startNow));
    chk("overrun", 64'(bus.overrun), 64'(expOv));
    chk("outSignal", 64'(bus.outSignal), 64'(expOut));
    if (bus.dataReady) begin
      readyCyc = cyc;
      dutReadies++;
    end
    if (startNow) begin
      curTap++;
      outstanding = 1;
      chk("macTap", 64'(bus.macTap), 64'(curTap));
      chk("macA", 64'(bus.macA), 64'(hist[curTap]));
      chk("macFirst", 64'(bus.macFirst), 64'(curTap == 0));
      capA[curTap] = bus.macA;
    end else if (outstanding) begin
      chk("holdTap", 64'(bus.macTap), 64'(curTap));
      chk("holdA", 64'(bus.macA), 64'(hist[curTap]));
    end
    if (doneNow) seqActive = 0;
    lastStart = startNow;
    doneSeen  = doneNow;

    bus.macAck    = 1'b0;
    bus.macResult = rnd33();
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        bus.macAck    = 1'b1;
        bus.macResult = acc;
        outstanding   = 0;
        if (curTap == NTAPS - 1) begin
          doneNext = 1;
          expOut   = acc;
        end else begin
          startDueNext = 1;
        end
      end
    end
    if (startNow) begin
      countdown = (ackDelay == 0) ? int'($urandom_range(1, 7)) : ackDelay;
      acc = ((curTap == 0) ? 33'd0 : acc) + prod(hist[curTap], curTap);
    end

    go = atDone ? doneNow : nd;
    bus.newData  = go;
    bus.inSignal = go ? din : rnd33();
    if (go) begin
      if (!seqActive) begin
        hist.push_front(din);
        void'(hist.pop_back());
        seqActive    = 1;
        startDueNext = 1;
        curTap       = -1;
        acceptCyc    = cyc;
        accepted++;
      end else begin
        expOv = 1;
      end
    end
  endtask

  task automatic finishSeq(input int dropOdds);
    int n = 0;
    while (seqActive && n < 1000) begin
      step((dropOdds > 0) && ($urandom_range(1, dropOdds) == 1), rnd33(), 0);
      n++;
    end
    chk("seqTimeout", 64'(seqActive), 64'd0);
  endtask

  task automatic runSample(input logic [32:0] s, input int dropOdds);
    step(1, s, 0);
    finishSeq(dropOdds);
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_macStart"}, 64'(bus.macStart), 64'd0);
    chk({tag, "_macA"}, 64'(bus.macA), 64'd0);
    chk({tag, "_macTap"}, 64'(bus.macTap), 64'd0);
    chk({tag, "_macFirst"}, 64'(bus.macFirst), 64'd0);
    chk({tag, "_outSignal"}, 64'(bus.outSignal), 64'd0);
    chk({tag, "_dataReady"}, 64'(bus.dataReady), 64'd0);
    chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; a stray ack follows the release.
  task automatic doReset(input string tag);
    rst = 1'b0;
    bus.newData = 1'b0;
    bus.macAck  = 1'b0;
    #1;
    chkResetVals(tag);
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.macAck    = 1'b1;
    bus.macResult = 33'h1_DEAD_BEEF;
    repeat (4) step(0, 33'd0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 12; i++) begin
      vecs[i].sample   = 33'(i + 1);
      vecs[i].expTap1  = (i >= 1) ? 33'(i) : 33'd0;
      vecs[i].expTap10 = (i >= 10) ? 33'(i - 9) : 33'd0;
    end
    bus.newData = 1'b0; bus.inSignal = '0; bus.macAck = 1'b0; bus.macResult = '0;
    modelReset();
    ackDelay = 1;
    repeat (3) @(negedge clk);
    #1 chkResetVals("initReset");
    rst = 1'b1;
    repeat (20) step(0, 33'd0, 0);

    // Single unit sample: latency, macFirst and zero history.
    runSample(33'h0_3F80_0000, 0);
    chk("latency", 64'(readyCyc - acceptCyc), 64'(2 * NTAPS + 1));
    chk("unitTap0", 64'(capA[0]), 64'h0_3F80_0000);
    for (int k = 1; k < NTAPS; k++) chk("unitTapZero", 64'(capA[k]), 64'd0);
    chk("unitOut", 64'(bus.outSignal), 64'(expOut));

    // Tagged samples 1..12 from a clean line: wraparound and oldest-sample discard.
    doReset("tblReset");
    for (int i = 0; i < 12; i++) begin
      runSample(vecs[i].sample, 0);
      chk("tblTap0", 64'(capA[0]), 64'(vecs[i].sample));
      chk("tblTap1", 64'(capA[1]), 64'(vecs[i].expTap1));
      chk("tblTap10", 64'(capA[NTAPS-1]), 64'(vecs[i].expTap10));
    end
    for (int k = 0; k < NTAPS; k++) chk("wrapTap", 64'(capA[k]), 64'(12 - k));

    // Back-to-back: newData in the dataReady cycle is accepted.
    step(1, 33'h0_00AA, 0);
    n = 0;
    while (!doneSeen && n < 500) begin
      step(0, 33'h0_00BB, 1);
      n++;
    end
    chk("b2bSeen", 64'(doneSeen), 64'd1);
    step(0, 33'd0, 0);
    chk("b2bStart", 64'(bus.macStart), 64'd1);
    chk("b2bOverrun", 64'(bus.overrun), 64'd0);
    finishSeq(0);
    chk("b2bTap0", 64'(capA[0]), 64'h0_00BB);
    chk("b2bTap1", 64'(capA[1]), 64'h0_00AA);

    // Drop during WAIT: overrun sticks, delay line untouched.
    ackDelay = 4;
    runSample(33'h0_0111, 0);
    step(1, 33'h0_0222, 0);
    step(0, 33'd0, 0);
    step(0, 33'd0, 0);
    step(1, 33'h0_0999, 0);
    finishSeq(0);
    runSample(33'h0_0333, 0);
    chk("dropOverrun", 64'(bus.overrun), 64'd1);
    chk("dropTap1", 64'(capA[1]), 64'h0_0222);
    chk("dropTap2", 64'(capA[2]), 64'h0_0111);

    // Random samples, random MAC latency, occasional mid-sequence newData.
    ackDelay = 0;
    for (int i = 0; i < 25; i++) begin
      runSample(rnd33(), 8);
      repeat ($urandom_range(0, 2)) step(0, 33'd0, 0);
    end
    chk("readyCount", 64'(dutReadies), 64'(accepted));

    // Reset in the WAIT of tap 5; afterwards history must be all zeros.
    ackDelay = 3;
    step(1, 33'h0_0ABC, 0);
    n = 0;
    while (!(outstanding && !lastStart && curTap == 5) && n < 300) begin
      step(0, 33'd0, 0);
      n++;
    end
    chk("reachTap5", 64'(curTap), 64'd5);
    doReset("midReset");
    ackDelay = 1;
    runSample(33'h0_4000_0000, 0);
    chk("postRstTap0", 64'(capA[0]), 64'h0_4000_0000);
    for (int k = 1; k < NTAPS; k++) chk("postRstZero", 64'(capA[k]), 64'd0);
    chk("postRstOverrun", 64'(bus.overrun), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/filter_mac_sequencer.md
Name: filter_mac_sequencer

Overview:
Controls the FIR filter path. It owns the NTAPS-deep sample delay line and steps one shared floating-point multiply-accumulate unit (MAC) through every tap for each new input sample. The MAC and the coefficient ROM are external. This block sits between the UART sample source and the FFT input, and gives the same newData/dataReady interface as the filter top level.

Parameters:
DATA_W, 33, width of one floating-point sample/result word
NTAPS, 11, number of filter taps (delay-line depth), 2..16
TAP_W, 4, width of the tap index, ceil(log2(NTAPS))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
inSignal  in  DATA_W  input sample, valid when newData=1
newData  in  1  one-cycle strobe, new sample present
macStart  out  1  one-cycle strobe, MAC operands valid
macA  out  DATA_W  sample operand for the current tap
macTap  out  TAP_W  current tap index, addresses the external coefficient ROM
macFirst  out  1  with macStart: clear the accumulator before this product
macAck  in  1  MAC finished the current product; macResult = running sum
macResult  in  DATA_W  MAC accumulator value
outSignal  out  DATA_W  filtered output, held until the next result
dataReady  out  1  one-cycle strobe, outSignal updated
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky; a sample was dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - all delay-line entries=0
  - wp=0
  - outSignal=0
  - macStart, macFirst, dataReady, overrun = 0
  - macA=0, macTap=0
- Reset takes effect mid-sequence with no completion. A later macAck is ignored.
- Delay line: circular, NTAPS entries, write pointer wp in 0..NTAPS-1. Tap k reads entry (wp_new - k) mod NTAPS, where wp_new is the slot that holds the newest sample. Tap 0 is the newest sample, tap NTAPS-1 the oldest.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - newData=1 → write inSignal to entry wp, latch wp_new=wp, tap=0, go to ISSUE.
  - wp advances (wrapping NTAPS-1 → 0) in the same cycle as the write.
- ISSUE (exactly one cycle):
  - macStart=1, macTap=tap, macA=sample of tap, macFirst=(tap==0).
  - Go to WAIT.
- WAIT:
  - Hold macA and macTap stable. macStart=0.
  - On macAck=1 with tap<NTAPS-1: tap+1, go to ISSUE.
  - On macAck=1 with tap==NTAPS-1: outSignal<=macResult, go to DONE.
  - MAC latency is unbounded; there is no timeout.
- DONE (one cycle):
  - dataReady=1. Return to IDLE.
  - newData=1 in DONE is accepted exactly as in IDLE (back-to-back samples): the next state is ISSUE, not IDLE.
- Latency: with a MAC that acks one cycle after macStart, the accept cycle is cycle 0, macStart tap0 is at cycle 1, and dataReady is at cycle 2*NTAPS+1 (23 for NTAPS=11).
- newData while in ISSUE or WAIT:
  - The sample is dropped and the delay line and wp are unchanged.
  - overrun is set to 1 and stays 1 until reset.
- macAck outside WAIT is ignored.
- macAck in the same cycle as the ISSUE strobe is not sampled; it is only sampled in WAIT.
- outSignal changes only on final-tap ack or reset. dataReady is never high for two consecutive cycles.
- No arithmetic is done on data; all float arithmetic is inside the MAC. Tap and pointer math is mod NTAPS and must handle NTAPS not being a power of 2.

Test Plan:
- Reset, then idle 20 cycles, MAC model acks 1 cycle after macStart → busy=0, macStart=0, outSignal=0, dataReady=0, overrun=0.
- Single sample 33'h0_3F80_0000 after reset → 11 macStart pulses:
  - Tap 0: macA=33'h0_3F80_0000, macFirst=1.
  - Taps 1..10: macA=0, macFirst=0.
  - macTap sequence 0..10.
  - dataReady at cycle 23; outSignal = the model's last macResult.
- Feed 12 samples tagged 33'h1..33'hC, each after the previous dataReady → on the 12th sample, macA for taps 0..10 = 33'hC,33'hB,…,33'h2. Checks wraparound and that the oldest sample is discarded.
- MAC model with random ack delay of 1..7 cycles → macA and macTap stable throughout WAIT; same tap order and result as zero-wait; dataReady exactly once per sample.
- newData pulse in the cycle of a dataReady → accepted: macStart for tap 0 in the next cycle, overrun stays 0. newData pulse during WAIT → dropped: overrun=1 and the next sequence's tap 1 is unchanged.
- Drop rst to 0 during the WAIT of tap 5, hold 3 cycles, release → all outputs are at their reset values immediately; a stray macAck is ignored; the next sample sees only zeros in taps 1..10.
